// File: rtl/spi_pkg.sv
// Shared types and defaults for the single-byte SPI master (mode 0, MSB first).
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_t;

  localparam int unsigned SPI_DATA_W_DEF  = 8;
  localparam int unsigned SPI_CLK_DIV_DEF = 2;

endpackage

// File: rtl/spi_phase_tick.sv
// Half-period counter: emits a one-cycle tick on the last cycle of every CLK_DIV-cycle phase.
module spi_phase_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == CntMax);
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_tx_rx.sv
// Single-word SPI master, mode 0, MSB first. Define SPI_LOOPBACK_EN to feed the shifter
// from a registered copy of mosi instead of the miso port.
module spi_master_tx_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = SPI_DATA_W_DEF,
  parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int unsigned PhW = $clog2(2 * DATA_W + 2);
  localparam logic [PhW-1:0] LastPhase = PhW'(2 * DATA_W + 1);
  localparam logic [PhW-1:0] LastFall  = PhW'(2 * DATA_W);

  spi_state_t        state_q, state_d;
  logic [PhW-1:0]    phase_q, phase_d, phase_nx;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic              tick;
  logic              miso_int;

`ifdef SPI_LOOPBACK_EN
  logic lb_q;
  logic unused_miso;
  assign unused_miso = miso;

  always_ff @(posedge clk) begin
    if (rst) begin
      lb_q <= 1'b0;
    end else begin
      lb_q <= mosi_q;
    end
  end

  assign miso_int = lb_q;
`else
  assign miso_int = miso;
`endif

  spi_phase_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state_q != IDLE),
    .tick(tick)
  );

  assign phase_nx = phase_q + PhW'(1);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          phase_d = '0;
          tx_sr_d = tx_data;
          rx_sr_d = '0;
          mosi_d  = tx_data[DATA_W-1];
          sclk_d  = 1'b0;
        end
      end
      SETUP, XFER, HOLD: begin
        if (tick) begin
          if (phase_q == LastPhase) begin
            state_d   = IDLE;
            phase_d   = '0;
            done_d    = 1'b1;
            rx_data_d = rx_sr_q;
            mosi_d    = 1'b0;
            sclk_d    = 1'b0;
          end else if (phase_nx == LastPhase) begin
            state_d = HOLD;
            phase_d = phase_nx;
          end else begin
            state_d = XFER;
            phase_d = phase_nx;
            if (phase_nx[0]) begin
              // Rising edge: slave data has been stable for a full half-period.
              sclk_d  = 1'b1;
              rx_sr_d = {rx_sr_q[DATA_W-2:0], miso_int};
            end else begin
              sclk_d = 1'b0;
              // Final falling edge has no further bit; mosi keeps the LSB through HOLD.
              if (phase_nx != LastFall) begin
                tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                mosi_d  = tx_sr_q[DATA_W-2];
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_tx_rx.sv
// Randomized bench for spi_master_tx_rx: a behavioural mode-0 slave and frame monitor
// observe one of two instances (N=2 and N=4) and are checked against spec timing.
module tb_spi_master_tx_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_a = 1'b0;
  logic         start_b = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         miso = 1'b0;

  logic         sclk_a, mosi_a, cs_n_a, busy_a, done_a;
  logic [W-1:0] rx_a;
  logic         sclk_b, mosi_b, cs_n_b, busy_b, done_b;
  logic [W-1:0] rx_b;

  spi_master_tx_rx #(.DATA_W(W), .CLK_DIV(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_data), .miso(miso),
    .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .busy(busy_a), .done(done_a), .rx_data(rx_a)
  );

  spi_master_tx_rx #(.DATA_W(W), .CLK_DIV(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_data), .miso(miso),
    .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .busy(busy_b), .done(done_b), .rx_data(rx_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor selects which instance it watches.
  logic         sel = 1'b0;
  logic         m_sclk, m_mosi, m_cs_n, m_busy, m_done;
  logic [W-1:0] m_rx;
  assign m_sclk = sel ? sclk_b : sclk_a;
  assign m_mosi = sel ? mosi_b : mosi_a;
  assign m_cs_n = sel ? cs_n_b : cs_n_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_rx   = sel ? rx_b : rx_a;

  function automatic int n_cur();
    return sel ? 4 : 2;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave and frame monitor state.
  logic [W-1:0] slave_word = '0;
  logic [W-1:0] mosi_bits = '0;
  logic [W-1:0] exp_tx = '0;
  logic         p_sclk = 1'b0;
  logic         p_cs_n = 1'b1;
  int rises = 0, bit_idx = 0, done_cnt = 0, bad_rise = 0, gap = 0, run = 0;
  int hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;
  int last_chg = 0, last_cs_rise = 0, t0 = 0;

  always @(posedge clk) begin
    #2;
    if (p_cs_n && !m_cs_n) begin
      gap      = cyc - last_cs_rise;
      last_chg = cyc;
      bit_idx  = 0;
      miso     = slave_word[W-1];
    end
    if (!p_cs_n && m_cs_n) last_cs_rise = cyc;
    if (m_sclk != p_sclk) begin
      run      = cyc - last_chg;
      last_chg = cyc;
      if (m_sclk) begin
        rises++;
        if (m_cs_n) bad_rise++;
        mosi_bits = {mosi_bits[W-2:0], m_mosi};
        if (run < lo_min) lo_min = run;
        if (run > lo_max) lo_max = run;
      end else begin
        if (run < hi_min) hi_min = run;
        if (run > hi_max) hi_max = run;
        bit_idx++;
        if (bit_idx < W) miso = slave_word[W-1-bit_idx];
      end
    end
    if (m_done) done_cnt++;
    p_sclk = m_sclk;
    p_cs_n = m_cs_n;
  end

  // Call away from the rising edge; start is high for the current cycle (t0).
  task automatic start_xfer(input logic [W-1:0] tx, input logic [W-1:0] sw);
    slave_word = sw;
    exp_tx     = tx;
    rises      = 0;
    mosi_bits  = '0;
    done_cnt   = 0;
    bad_rise   = 0;
    hi_min     = 1000;
    hi_max     = 0;
    lo_min     = 1000;
    lo_max     = 0;
    t0         = cyc;
    tx_data    = tx;
    if (sel) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    tx_data = W'($urandom);
  endtask

  task automatic finish_xfer(input string tag, input bit chk_gap);
    bit           got;
    int           n;
    logic [W-1:0] exp_rx;
    got = 1'b0;
    n   = n_cur();
`ifdef SPI_LOOPBACK_EN
    exp_rx = exp_tx;
`else
    exp_rx = slave_word;
`endif
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_done) begin
        got = 1'b1;
        break;
      end
    end
    check_eq({tag, " done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check_eq({tag, " done_latency"}, 32'(cyc - t0), 32'((2 * W + 2) * n + 1));
      check_eq({tag, " rx_data"}, 32'(m_rx), 32'(exp_rx));
      check_eq({tag, " busy_at_done"}, 32'(m_busy), 32'd0);
      check_eq({tag, " cs_n_at_done"}, 32'(m_cs_n), 32'd1);
      check_eq({tag, " mosi_at_done"}, 32'(m_mosi), 32'd0);
    end
    check_eq({tag, " sclk_rises"}, 32'(rises), 32'(W));
    check_eq({tag, " mosi_bits"}, 32'(mosi_bits), 32'(exp_tx));
    check_eq({tag, " sclk_hi_min"}, 32'(hi_min), 32'(n));
    check_eq({tag, " sclk_hi_max"}, 32'(hi_max), 32'(n));
    check_eq({tag, " sclk_lo_min"}, 32'(lo_min), 32'(n));
    check_eq({tag, " sclk_lo_max"}, 32'(lo_max), 32'(n));
    check_eq({tag, " rise_outside_cs"}, 32'(bad_rise), 32'd0);
    check_eq({tag, " done_count"}, 32'(done_cnt), 32'd1);
    if (chk_gap) check_eq({tag, " cs_gap"}, 32'(gap), 32'd1);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    repeat (3) @(negedge clk);
    check_eq("reset sclk", 32'(sclk_a), 32'd0);
    check_eq("reset mosi", 32'(mosi_a), 32'd0);
    check_eq("reset cs_n", 32'(cs_n_a), 32'd1);
    check_eq("reset busy", 32'(busy_a), 32'd0);
    check_eq("reset done", 32'(done_a), 32'd0);
    check_eq("reset rx_data", 32'(rx_a), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed A5 with slave returning 3C.
    start_xfer(8'hA5, 8'h3C);
    check_eq("t1 cs_n_low_t0+1", 32'(cs_n_a), 32'd0);
    check_eq("t1 busy_t0+1", 32'(busy_a), 32'd1);
    finish_xfer("t1", 1'b0);
    repeat (3) @(negedge clk);

    // Back-to-back frames, each started in the previous done cycle.
    start_xfer(8'h00, W'($urandom));
    finish_xfer("t2a", 1'b0);
    start_xfer(8'hFF, W'($urandom));
    finish_xfer("t2b", 1'b1);
    start_xfer(8'h81, W'($urandom));
    finish_xfer("t2c", 1'b1);
    repeat (2) @(negedge clk);

    // Start pulses while busy are ignored.
    start_xfer(8'h69, 8'h96);
    wait_cyc(t0 + 5);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_cyc(t0 + 20);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    finish_xfer("t3", 1'b0);
    repeat (6) @(negedge clk);
    check_eq("t3 idle_after", 32'(busy_a), 32'd0);
    check_eq("t3 no_extra_rises", 32'(rises), 32'(W));

    // Reset mid-transfer.
    start_xfer(W'($urandom), W'($urandom));
    wait_cyc(t0 + 15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t4 cs_n", 32'(cs_n_a), 32'd1);
    check_eq("t4 sclk", 32'(sclk_a), 32'd0);
    check_eq("t4 busy", 32'(busy_a), 32'd0);
    check_eq("t4 rx_data", 32'(rx_a), 32'd0);
    check_eq("t4 done", 32'(done_a), 32'd0);
    repeat (45) @(negedge clk);
    check_eq("t4 no_done", 32'(done_cnt), 32'd0);
    start_xfer(W'($urandom), W'($urandom));
    finish_xfer("t4 restart", 1'b0);
    repeat (2) @(negedge clk);

    // rst and start together: rst wins.
    rst     = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    start_a = 1'b0;
    lows    = 0;
    for (int i = 0; i < 6; i++) begin
      if (!cs_n_a || busy_a) lows++;
      @(negedge clk);
    end
    check_eq("t6 no_transfer", 32'(lows), 32'd0);

    // Slower divider instance.
    sel = 1'b1;
    @(negedge clk);
    start_xfer(8'h5A, W'($urandom));
    finish_xfer("t5", 1'b0);
    for (int i = 0; i < 3; i++) begin
      start_xfer(W'($urandom), W'($urandom));
      finish_xfer("t5 rand", i > 0);
    end
    repeat (2) @(negedge clk);
    sel = 1'b0;
    @(negedge clk);

    // Randomized frames with random idle gaps or back-to-back starts.
    for (int i = 0; i < 12; i++) begin
      bit b2b;
      b2b = (i > 0) && ($urandom_range(0, 1) == 1);
      if (!b2b) repeat ($urandom_range(1, 5)) @(negedge clk);
      start_xfer(W'($urandom), W'($urandom));
      finish_xfer("rand", b2b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
